// File: rtl/key_step_gen.sv
// key_step_gen: debounced key to single-step pulses with delayed auto-repeat, long-press flag and step counter
module key_step_gen #(
    parameter int DELAY_TICKS = 8,
    parameter int RATE_TICKS  = 4,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 Clk,
    input  logic                 Srst_n,
    input  logic                 di_Key,
    input  logic                 di_Press,
    input  logic                 di_DePrs,
    input  logic                 di_Clr,
    output logic                 do_Step,
    output logic                 do_Long,
    output logic                 do_Rpt,
    output logic [CNT_WIDTH-1:0] do_Cnt
);
    localparam int MAX_TICKS = DELAY_TICKS > RATE_TICKS ? DELAY_TICKS : RATE_TICKS;
    localparam int TW        = $clog2(MAX_TICKS);

    if (DELAY_TICKS < 2 || RATE_TICKS < 2) begin : g_bad_params
        $error("key_step_gen: DELAY_TICKS and RATE_TICKS must both be >= 2");
    end

    typedef enum logic [1:0] {IDLE, HOLD, REPEAT} state_t;

    state_t                state_q, state_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic                  step_q, step_d;
    logic                  long_q, long_d;
    logic                  rpt_q, rpt_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  rel;

    // Next-state: release beats any timer expiry; presses only count from IDLE with the key down
    always_comb begin
        rel     = di_DePrs | ~di_Key;
        state_d = state_q;
        timer_d = timer_q;
        step_d  = 1'b0;
        long_d  = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (di_Press && di_Key) begin
                    state_d = HOLD;
                    step_d  = 1'b1;
                end
            end
            HOLD: begin
                if (rel) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(DELAY_TICKS - 1)) begin
                    state_d = REPEAT;
                    timer_d = '0;
                    step_d  = 1'b1;
                    long_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            REPEAT: begin
                if (rel) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else if (timer_q == TW'(RATE_TICKS - 1)) begin
                    timer_d = '0;
                    step_d  = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        rpt_d = state_d == REPEAT;
        cnt_d = di_Clr ? '0 : step_d ? cnt_q + 1'b1 : cnt_q;
    end

    // State, timer and registered outputs
    always_ff @(posedge Clk or negedge Srst_n) begin
        if (!Srst_n) begin
            state_q <= IDLE;
            timer_q <= '0;
            step_q  <= 1'b0;
            long_q  <= 1'b0;
            rpt_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            step_q  <= step_d;
            long_q  <= long_d;
            rpt_q   <= rpt_d;
            cnt_q   <= cnt_d;
        end
    end

    assign do_Step = step_q;
    assign do_Long = long_q;
    assign do_Rpt  = rpt_q;
    assign do_Cnt  = cnt_q;
endmodule

// File: tb/tb_key_step_gen.sv
// tb_key_step_gen: directed and randomized check of key_step_gen against a timeline reference model
module tb_key_step_gen;
    localparam int D = 8;
    localparam int R = 4;

    logic       Clk = 1'b0, Srst_n = 1'b0;
    logic       key = 1'b0, press = 1'b0, deprs = 1'b0, clr = 1'b0;
    logic       step, lng, rpt, step2, lng2, rpt2;
    logic [7:0] cnt;
    logic [1:0] cnt2;

    int n_tests = 0, n_fail = 0;

    // reference: hold age in edges since the accepted press
    bit m_act, m_step, m_long, m_rpt;
    int m_age, m_cnt, m_cnt2;

    key_step_gen #(.DELAY_TICKS(D), .RATE_TICKS(R), .CNT_WIDTH(8)) dut (
        .Clk(Clk), .Srst_n(Srst_n), .di_Key(key), .di_Press(press), .di_DePrs(deprs), .di_Clr(clr),
        .do_Step(step), .do_Long(lng), .do_Rpt(rpt), .do_Cnt(cnt)
    );

    key_step_gen #(.DELAY_TICKS(D), .RATE_TICKS(R), .CNT_WIDTH(2)) dut2 (
        .Clk(Clk), .Srst_n(Srst_n), .di_Key(key), .di_Press(press), .di_DePrs(deprs), .di_Clr(clr),
        .do_Step(step2), .do_Long(lng2), .do_Rpt(rpt2), .do_Cnt(cnt2)
    );

    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_act = 0; m_age = 0; m_step = 0; m_long = 0; m_rpt = 0; m_cnt = 0; m_cnt2 = 0;
    endtask

    task automatic model_edge();
        if (!Srst_n) begin
            model_reset();
            return;
        end
        m_step = 0; m_long = 0; m_rpt = 0;
        if (m_act) begin
            if (deprs || !key) m_act = 0;
            else begin
                m_age++;
                m_step = m_age >= D && (m_age - D) % R == 0;
                m_long = m_age == D;
                m_rpt  = m_age >= D;
            end
        end else if (press && key) begin
            m_act = 1; m_age = 0; m_step = 1;
        end
        m_cnt  = clr ? 0 : (m_cnt + int'(m_step)) % 256;
        m_cnt2 = clr ? 0 : (m_cnt2 + int'(m_step)) % 4;
    endtask

    task automatic check_all();
        check("step", step, m_step);
        check("long", lng, m_long);
        check("rpt", rpt, m_rpt);
        check("cnt", cnt, m_cnt);
        check("cnt2", cnt2, m_cnt2);
        check("step2", step2, m_step);
    endtask

    task automatic cyc(input bit k, input bit p, input bit dp, input bit c);
        key = k; press = p; deprs = dp; clr = c;
        model_edge();
        @(posedge Clk);
        #1;
        check_all();
    endtask

    // press accepted on the first edge, key held for n-1 more edges, release seen on the next
    task automatic hold(input int n);
        cyc(1, 1, 0, 0);
        for (int i = 1; i < n; i++) cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
    endtask

    initial begin
        int run;
        bit k, prev, p, dp, c;
        model_reset();
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        check("rst_cnt", cnt, 0);
        Srst_n = 1'b1;
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0);

        cyc(0, 0, 0, 1);
        hold(4);
        check("short_cnt", cnt, 1);

        cyc(0, 0, 0, 1);
        hold(30);
        check("long_cnt", cnt, 7);

        cyc(0, 0, 0, 1);
        hold(8);
        check("collide_cnt", cnt, 1);

        cyc(0, 0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            hold(2);
            check("wrap_cnt2", cnt2, (i + 1) % 4);
            cyc(0, 0, 0, 0);
        end
        cyc(1, 1, 0, 1);
        check("clr_step", step, 1);
        check("clr_cnt", cnt, 0);
        cyc(0, 0, 1, 0);

        cyc(0, 1, 0, 0);
        check("press_nokey", step, 0);
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 0);
        for (int i = 1; i < 20; i++) cyc(1, (i == 10 || i == 13), 0, 0);
        check("rpt_press_cnt", cnt, 4);

        #2 Srst_n = 1'b0;
        #1;
        check("async_step", step, 0);
        check("async_rpt", rpt, 0);
        check("async_cnt", cnt, 0);
        model_reset();
        cyc(1, 0, 0, 0);
        Srst_n = 1'b1;
        for (int i = 0; i < 15; i++) cyc(1, 0, 0, 0);
        check("post_rst_cnt", cnt, 0);
        cyc(0, 0, 1, 0);

        run = 0; k = 0; prev = 0;
        for (int i = 0; i < 3000; i++) begin
            if (run == 0) begin
                k = ~k;
                run = $urandom_range(1, 40);
            end
            run--;
            p  = (k && !prev && $urandom_range(0, 9) != 0) || $urandom_range(0, 31) == 0;
            dp = (!k && prev && $urandom_range(0, 1) == 1) || $urandom_range(0, 49) == 0;
            c  = $urandom_range(0, 31) == 0;
            cyc(k, p, dp, c);
            prev = k;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
